// File: rtl/wishbone_sdram_slave.sv
// rtl/wishbone_sdram_slave.sv - Wishbone word slave split into 16-bit SDRAM command beats
module wishbone_sdram_slave #(
    parameter int MEM_WORD_BITS = 24
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic [29:0]              addr,
    input  logic [31:0]              data_write,
    input  logic [3:0]               sel,
    input  logic                     cyc,
    input  logic                     stb,
    input  logic                     we,
    input  logic [2:0]               cti,
    input  logic [1:0]               bte,
    output logic [31:0]              data_read,
    output logic                     ack,
    output logic                     err,
    output logic                     mem_req,
    input  logic                     mem_ready,
    output logic                     mem_we,
    output logic [MEM_WORD_BITS:0]   mem_addr,
    output logic [15:0]              mem_wdata,
    output logic [1:0]               mem_be,
    input  logic                     mem_rvalid,
    input  logic [15:0]              mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        CMD_LO,
        CMD_HI,
        WAIT_RD,
        RESP
    } state_t;

    state_t                   state, state_next;
    logic [MEM_WORD_BITS-1:0] addr_q;
    logic                     we_q;
    logic [3:0]               sel_q;
    logic [31:0]              wdata_q;
    logic                     err_q;
    logic [1:0]               beat_cnt;
    logic [31:0]              rdata_q;

    logic request, out_of_range, accepted, rd_beat, rd_done, is_hi;
    logic unused_ok;

    // Burst hints are irrelevant: every access is a classic single-word cycle.
    assign unused_ok    = ^{cti, bte};

    assign request      = cyc && stb;
    assign out_of_range = (addr >> MEM_WORD_BITS) != '0;
    assign accepted     = mem_req && mem_ready;
    assign rd_beat      = mem_rvalid &&
                          (state == CMD_LO || state == CMD_HI || state == WAIT_RD);
    // Lookahead lets a second beat landing this cycle move straight to RESP.
    assign rd_done      = (beat_cnt == 2'd2) || (beat_cnt == 2'd1 && rd_beat);
    assign is_hi        = (state == CMD_HI);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (request) begin
                    if (out_of_range)
                        state_next = RESP;
                    else if (we && sel == 4'b0000)
                        state_next = RESP;
                    else if (we && sel[1:0] == 2'b00)
                        state_next = CMD_HI;
                    else
                        state_next = CMD_LO;
                end
            end
            CMD_LO: begin
                if (accepted)
                    state_next = (we_q && sel_q[3:2] == 2'b00) ? RESP : CMD_HI;
            end
            CMD_HI: begin
                if (accepted)
                    state_next = we_q ? RESP : WAIT_RD;
            end
            WAIT_RD: begin
                if (rd_done)
                    state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            addr_q   <= '0;
            we_q     <= 1'b0;
            sel_q    <= 4'b0000;
            wdata_q  <= 32'h0;
            err_q    <= 1'b0;
            beat_cnt <= 2'd0;
            rdata_q  <= 32'h0;
        end else if (state == IDLE && request) begin
            addr_q   <= addr[MEM_WORD_BITS-1:0];
            we_q     <= we;
            sel_q    <= sel;
            wdata_q  <= data_write;
            err_q    <= out_of_range;
            beat_cnt <= 2'd0;
            if (out_of_range)
                rdata_q <= 32'h0;
        end else if (rd_beat) begin
            beat_cnt <= beat_cnt + 2'd1;
            if (beat_cnt == 2'd0)
                rdata_q[15:0] <= mem_rdata;
            else if (beat_cnt == 2'd1)
                rdata_q[31:16] <= mem_rdata;
        end
    end

    // Memory command outputs depend only on state and latched request fields.
    assign mem_req   = (state == CMD_LO) || (state == CMD_HI);
    assign mem_we    = mem_req && we_q;
    assign mem_addr  = mem_req ? {addr_q, is_hi} : '0;
    assign mem_wdata = mem_req ? (is_hi ? wdata_q[31:16] : wdata_q[15:0]) : 16'h0;
    assign mem_be    = !mem_req ? 2'b00 :
                       !we_q    ? 2'b11 :
                       is_hi    ? sel_q[3:2] : sel_q[1:0];

    assign ack       = (state == RESP) && cyc && !err_q;
    assign err       = (state == RESP) && cyc && err_q;
    assign data_read = rdata_q;

endmodule

// File: tb/tb_wishbone_sdram_slave.sv
// tb/tb_wishbone_sdram_slave.sv - directed vector bench for wishbone_sdram_slave
module tb_wishbone_sdram_slave;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [29:0] addr;
    logic [31:0] data_write;
    logic [3:0]  sel;
    logic        cyc, stb, we;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] data_read;
    logic        ack, err;
    logic        mem_req, mem_ready, mem_we;
    logic [24:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_be;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;

    wishbone_sdram_slave #(.MEM_WORD_BITS(24)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .addr       (addr),
        .data_write (data_write),
        .sel        (sel),
        .cyc        (cyc),
        .stb        (stb),
        .we         (we),
        .cti        (cti),
        .bte        (bte),
        .data_read  (data_read),
        .ack        (ack),
        .err        (err),
        .mem_req    (mem_req),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [29:0] a;
        logic        w;
        logic [3:0]  s;
        logic [31:0] d;
        logic [15:0] rd0;
        logic [15:0] rd1;
        int          exp_cycle;
        logic        exp_err;
        int          exp_beats;
        logic [24:0] b0_addr;
        logic [15:0] b0_data;
        logic [1:0]  b0_be;
        logic [24:0] b1_addr;
        logic [15:0] b1_data;
        logic [1:0]  b1_be;
        logic [31:0] exp_rdata;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    int          res_ack_cyc, res_err_cyc, res_acks, res_errs, res_nbeats, res_nrvalid;
    logic [31:0] res_rdata;
    logic [24:0] b_addr [4];
    logic [15:0] b_data [4];
    logic [1:0]  b_be   [4];
    logic        b_we   [4];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One Wishbone transaction with a small in-order memory responder; bounded to 40 cycles.
    task automatic run_txn(input logic [29:0] a, input logic w, input logic [3:0] s,
                           input logic [31:0] d, input logic [31:0] rdy_pat,
                           input int lat0, input int lat1,
                           input logic [15:0] rd0, input logic [15:0] rd1, input int drop_at);
        int          due[$];
        logic [15:0] dq[$];
        int          last_due, tail, rd_issued, t;
        res_ack_cyc = -1; res_err_cyc = -1; res_acks = 0; res_errs = 0;
        res_nbeats = 0; res_nrvalid = 0; res_rdata = 32'hx;
        last_due = 0; tail = -1; rd_issued = 0;
        @(negedge clk_sys);
        addr = a; we = w; sel = s; data_write = d; cyc = 1'b1; stb = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_sys);
            if (ack) begin
                res_acks++;
                if (res_ack_cyc < 0) begin res_ack_cyc = k; res_rdata = data_read; end
                tail = k;
            end
            if (err) begin
                res_errs++;
                if (res_err_cyc < 0) begin res_err_cyc = k; res_rdata = data_read; end
                tail = k;
            end
            mem_ready = (k < 32) ? rdy_pat[k] : 1'b1;
            if (mem_req && mem_ready) begin
                if (res_nbeats < 4) begin
                    b_addr[res_nbeats] = mem_addr;
                    b_data[res_nbeats] = mem_wdata;
                    b_be[res_nbeats]   = mem_be;
                    b_we[res_nbeats]   = mem_we;
                end
                if (!mem_we) begin
                    t = k + ((rd_issued == 0) ? lat0 : lat1);
                    if (t <= last_due) t = last_due + 1;
                    last_due = t;
                    due.push_back(t);
                    dq.push_back((rd_issued == 0) ? rd0 : rd1);
                    rd_issued++;
                end
                res_nbeats++;
            end
            mem_rvalid = 1'b0;
            if (due.size() > 0 && due[0] == k) begin
                mem_rvalid = 1'b1;
                mem_rdata  = dq.pop_front();
                void'(due.pop_front());
                res_nrvalid++;
            end
            if (k == drop_at || (tail >= 0 && k == tail + 1)) begin
                cyc = 1'b0; stb = 1'b0;
            end
            if (tail >= 0 && k >= tail + 4) break;
        end
        mem_rvalid = 1'b0;
        mem_ready  = 1'b1;
        cyc = 1'b0; stb = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{30'h10, 1'b1, 4'hF, 32'hA1B2C3D4, 16'h0, 16'h0, 3, 1'b0, 2,
                    25'h20, 16'hC3D4, 2'b11, 25'h21, 16'hA1B2, 2'b11, 32'h0};
        vecs[1] = '{30'h10, 1'b1, 4'b1100, 32'h55667788, 16'h0, 16'h0, 2, 1'b0, 1,
                    25'h21, 16'h5566, 2'b11, 25'h0, 16'h0, 2'b00, 32'h0};
        vecs[2] = '{30'h10, 1'b1, 4'b0000, 32'hFFFFFFFF, 16'h0, 16'h0, 1, 1'b0, 0,
                    25'h0, 16'h0, 2'b00, 25'h0, 16'h0, 2'b00, 32'h0};
        vecs[3] = '{30'h7, 1'b1, 4'b0011, 32'h12345678, 16'h0, 16'h0, 2, 1'b0, 1,
                    25'h0E, 16'h5678, 2'b11, 25'h0, 16'h0, 2'b00, 32'h0};
        vecs[4] = '{30'hFFFFFF, 1'b1, 4'b0110, 32'hDEADBEEF, 16'h0, 16'h0, 3, 1'b0, 2,
                    25'h1FFFFFE, 16'hBEEF, 2'b10, 25'h1FFFFFF, 16'hDEAD, 2'b01, 32'h0};
        vecs[5] = '{30'h5, 1'b0, 4'hF, 32'h0, 16'hAAAA, 16'h5555, 5, 1'b0, 2,
                    25'h0A, 16'h0, 2'b11, 25'h0B, 16'h0, 2'b11, 32'h5555AAAA};
        vecs[6] = '{30'h01000000, 1'b0, 4'hF, 32'h0, 16'h0, 16'h0, 1, 1'b1, 0,
                    25'h0, 16'h0, 2'b00, 25'h0, 16'h0, 2'b00, 32'h0};
        vecs[7] = '{30'h3FFFFFFF, 1'b1, 4'hF, 32'h9999, 16'h0, 16'h0, 1, 1'b1, 0,
                    25'h0, 16'h0, 2'b00, 25'h0, 16'h0, 2'b00, 32'h0};

        reset_n = 1'b0; addr = '0; data_write = '0; sel = '0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = '0; bte = '0;
        mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk_sys);
        check("reset_outputs", 64'({ack, err, data_read, mem_req, mem_we, mem_addr, mem_wdata, mem_be}), 64'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].a, vecs[i].w, vecs[i].s, vecs[i].d, 32'hFFFFFFFF, 2, 2,
                    vecs[i].rd0, vecs[i].rd1, -1);
            if (vecs[i].exp_err) begin
                check($sformatf("v%0d_err_cycle", i), 64'(res_err_cyc), 64'(vecs[i].exp_cycle));
                check($sformatf("v%0d_err_count", i), 64'(res_errs), 64'd1);
                check($sformatf("v%0d_ack_count", i), 64'(res_acks), 64'd0);
            end else begin
                check($sformatf("v%0d_ack_cycle", i), 64'(res_ack_cyc), 64'(vecs[i].exp_cycle));
                check($sformatf("v%0d_ack_count", i), 64'(res_acks), 64'd1);
                check($sformatf("v%0d_err_count", i), 64'(res_errs), 64'd0);
            end
            check($sformatf("v%0d_beats", i), 64'(res_nbeats), 64'(vecs[i].exp_beats));
            if (vecs[i].exp_beats >= 1 && res_nbeats >= 1) begin
                check($sformatf("v%0d_b0_addr", i), 64'(b_addr[0]), 64'(vecs[i].b0_addr));
                check($sformatf("v%0d_b0_be", i), 64'(b_be[0]), 64'(vecs[i].b0_be));
                check($sformatf("v%0d_b0_we", i), 64'(b_we[0]), 64'(vecs[i].w));
                if (vecs[i].w)
                    check($sformatf("v%0d_b0_data", i), 64'(b_data[0]), 64'(vecs[i].b0_data));
            end
            if (vecs[i].exp_beats >= 2 && res_nbeats >= 2) begin
                check($sformatf("v%0d_b1_addr", i), 64'(b_addr[1]), 64'(vecs[i].b1_addr));
                check($sformatf("v%0d_b1_be", i), 64'(b_be[1]), 64'(vecs[i].b1_be));
                check($sformatf("v%0d_b1_we", i), 64'(b_we[1]), 64'(vecs[i].w));
                if (vecs[i].w)
                    check($sformatf("v%0d_b1_data", i), 64'(b_data[1]), 64'(vecs[i].b1_data));
            end
            if (!vecs[i].w || vecs[i].exp_err)
                check($sformatf("v%0d_rdata", i), 64'(res_rdata), 64'(vecs[i].exp_rdata));
        end

        // Read with mem_ready toggling and latencies 1 and 4: first beat lands in CMD_HI.
        run_txn(30'h3, 1'b0, 4'hF, 32'h0, 32'hAAAAAAAA, 1, 4, 16'h1111, 16'h2222, -1);
        check("toggle_ack_cycle", 64'(res_ack_cyc), 64'd8);
        check("toggle_ack_count", 64'(res_acks), 64'd1);
        check("toggle_beats", 64'(res_nbeats), 64'd2);
        check("toggle_b0_addr", 64'(b_addr[0]), 64'h6);
        check("toggle_b1_addr", 64'(b_addr[1]), 64'h7);
        check("toggle_rdata", 64'(res_rdata), 64'h22221111);

        // Master drops cyc during WAIT_RD: beats drain, no termination.
        run_txn(30'h8, 1'b0, 4'hF, 32'h0, 32'hFFFFFFFF, 2, 2, 16'hBEEF, 16'hCAFE, 3);
        check("abort_ack_count", 64'(res_acks), 64'd0);
        check("abort_err_count", 64'(res_errs), 64'd0);
        check("abort_beats", 64'(res_nbeats), 64'd2);
        check("abort_rvalids", 64'(res_nrvalid), 64'd2);

        run_txn(30'h20, 1'b0, 4'hF, 32'h0, 32'hFFFFFFFF, 1, 1, 16'h3333, 16'h4444, -1);
        check("post_abort_ack_cycle", 64'(res_ack_cyc), 64'd4);
        check("post_abort_ack_count", 64'(res_acks), 64'd1);
        check("post_abort_rdata", 64'(res_rdata), 64'h44443333);

        // Reset asserted while CMD_HI is stalled by mem_ready low.
        @(negedge clk_sys);
        addr = 30'h40; we = 1'b1; sel = 4'b1100; data_write = 32'h76543210;
        cyc = 1'b1; stb = 1'b1; mem_ready = 1'b0;
        @(negedge clk_sys);
        check("stall_req_c1", 64'({mem_req, mem_we, mem_addr, mem_wdata, mem_be}),
              64'({1'b1, 1'b1, 25'h81, 16'h7654, 2'b11}));
        @(negedge clk_sys);
        check("stall_req_c2", 64'({mem_req, mem_we, mem_addr, mem_wdata, mem_be}),
              64'({1'b1, 1'b1, 25'h81, 16'h7654, 2'b11}));
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", 64'({ack, err, data_read, mem_req, mem_we, mem_addr, mem_wdata, mem_be}), 64'h0);
        cyc = 1'b0; stb = 1'b0; mem_ready = 1'b1;
        @(negedge clk_sys);
        reset_n = 1'b1;

        run_txn(30'h10, 1'b1, 4'hF, 32'h0BADF00D, 32'hFFFFFFFF, 2, 2, 16'h0, 16'h0, -1);
        check("post_reset_ack_cycle", 64'(res_ack_cyc), 64'd3);
        check("post_reset_ack_count", 64'(res_acks), 64'd1);
        check("post_reset_beats", 64'(res_nbeats), 64'd2);
        check("post_reset_b0_data", 64'(b_data[0]), 64'hF00D);
        check("post_reset_b1_data", 64'(b_data[1]), 64'h0BAD);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
